// File: rtl/processador_uc.sv
// Multicycle control unit for the RV64I core: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes.
// Optional macro UC_ILLEGAL_TRAP_EN: illegal opcodes set a sticky flag and halt the core instead of acting as NOP.
module processador_uc #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 imem_valid,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 IR_load,
    output logic                 PC_load,
    output logic                 rf_we,
    output logic                 JAL,
    output logic                 JALR,
    output logic [1:0]           OP_MEM_I,
    output logic [1:0]           ULAop,
    output logic                 dmem_rd,
    output logic                 dmem_wr,
    output logic [INSTRET_W-1:0] instret,
    output logic                 illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_LOAD, C_STORE, C_OP, C_OPIMM, C_BRANCH, C_JAL, C_JALR, C_AUIPC, C_LUI, C_ILLEGAL
    } opc_class_t;

    function automatic opc_class_t classify(input logic [6:0] op);
        case (op)
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0110011: return C_OP;
            7'b0010011: return C_OPIMM;
            7'b1100011: return C_BRANCH;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0010111: return C_AUIPC;
            7'b0110111: return C_LUI;
            default:    return C_ILLEGAL;
        endcase
    endfunction

    function automatic logic [1:0] ula_for(input opc_class_t c);
        case (c)
            C_BRANCH: return 2'b01;
            C_OP:     return 2'b10;
            C_OPIMM:  return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

    state_t                 state_reg, state_next;
    logic [6:0]             opc_reg;
    logic [INSTRET_W-1:0]   instret_reg;
    opc_class_t             cls;

    logic       imem_req_c, pc_load_c, rf_we_c, jal_c, jalr_c, dmem_rd_c, dmem_wr_c;
    logic [1:0] op_mem_c, ula_c;

    assign cls = classify(opc_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            opc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                opc_reg <= opcode;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (imem_valid) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_BRANCH, C_JAL, C_JALR:      state_next = S_FETCH;
                    C_OP, C_OPIMM, C_AUIPC, C_LUI: state_next = S_WB;
                    C_LOAD, C_STORE:              state_next = S_MEM;
`ifdef UC_ILLEGAL_TRAP_EN
                    default:                      state_next = S_HALT;
`else
                    default:                      state_next = S_FETCH;
`endif
                endcase
            end
            S_MEM:    if (dmem_ready) state_next = (cls == C_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Moore strobes from state and latched opcode; STORE completion in MEM is the only input-qualified retire.
    always_comb begin
        imem_req_c = 1'b0;
        pc_load_c  = 1'b0;
        rf_we_c    = 1'b0;
        jal_c      = 1'b0;
        jalr_c     = 1'b0;
        dmem_rd_c  = 1'b0;
        dmem_wr_c  = 1'b0;
        op_mem_c   = 2'b00;
        ula_c      = 2'b00;
        case (state_reg)
            S_FETCH: imem_req_c = 1'b1;
            S_EXEC: begin
                ula_c = ula_for(cls);
                case (cls)
                    C_BRANCH: pc_load_c = 1'b1;
                    C_JAL: begin
                        jal_c = 1'b1; op_mem_c = 2'b11; rf_we_c = 1'b1; pc_load_c = 1'b1;
                    end
                    C_JALR: begin
                        jalr_c = 1'b1; op_mem_c = 2'b11; rf_we_c = 1'b1; pc_load_c = 1'b1;
                    end
`ifndef UC_ILLEGAL_TRAP_EN
                    C_ILLEGAL: pc_load_c = 1'b1;
`endif
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_rd_c = (cls == C_LOAD);
                dmem_wr_c = (cls == C_STORE);
                pc_load_c = (cls == C_STORE) && dmem_ready;
            end
            S_WB: begin
                rf_we_c   = 1'b1;
                pc_load_c = 1'b1;
                ula_c     = ula_for(cls);
                if (cls == C_LOAD)
                    op_mem_c = 2'b01;
                else if (cls == C_AUIPC || cls == C_LUI)
                    op_mem_c = 2'b10;
            end
            default: ;
        endcase
    end

    // Qualify every strobe with reset so they fall the instant reset goes low.
    assign imem_req = reset & imem_req_c;
    assign IR_load  = reset & imem_valid & (state_reg == S_FETCH);
    assign PC_load  = reset & pc_load_c;
    assign rf_we    = reset & rf_we_c;
    assign JAL      = reset & jal_c;
    assign JALR     = reset & jalr_c;
    assign dmem_rd  = reset & dmem_rd_c;
    assign dmem_wr  = reset & dmem_wr_c;
    assign OP_MEM_I = reset ? op_mem_c : 2'b00;
    assign ULAop    = reset ? ula_c : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            instret_reg <= '0;
        else if (pc_load_c)
            instret_reg <= instret_reg + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
    assign instret = instret_reg;

`ifdef UC_ILLEGAL_TRAP_EN
    logic illegal_reg;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            illegal_reg <= 1'b0;
        else if (state_reg == S_EXEC && cls == C_ILLEGAL)
            illegal_reg <= 1'b1;
    end
    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_processador_uc.sv
// Randomized bench for processador_uc: a per-instruction cycle script is built from the opcode-class rules and replayed.
module tb_processador_uc;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [6:0]   opcode;
    logic         imem_valid, dmem_ready;
    logic         imem_req, IR_load, PC_load, rf_we, JAL, JALR, dmem_rd, dmem_wr, illegal;
    logic [1:0]   OP_MEM_I, ULAop;
    logic [W-1:0] instret;

    int checks = 0;
    int errors = 0;
    int model_count = 0;

    always #5 clk = ~clk;

    processador_uc #(.INSTRET_W(W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .IR_load(IR_load), .PC_load(PC_load), .rf_we(rf_we), .JAL(JAL), .JALR(JALR),
        .OP_MEM_I(OP_MEM_I), .ULAop(ULAop), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .instret(instret), .illegal(illegal)
    );

    typedef struct {
        logic [6:0]  op;
        logic        iv;
        logic        dr;
        logic [11:0] exp;
        string       ph;
    } cyc_t;

    // Instruction classes: 0 LOAD 1 STORE 2 OP 3 OPIMM 4 BRANCH 5 JAL 6 JALR 7 AUIPC 8 LUI 9 ILLEGAL
    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b0110011: return 2;
            7'b0010011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            7'b1100111: return 6;
            7'b0010111: return 7;
            7'b0110111: return 8;
            default:    return 9;
        endcase
    endfunction

    function automatic logic [1:0] ula_of(input int c);
        return (c == 4) ? 2'b01 : (c == 2) ? 2'b10 : (c == 3) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [11:0] pk(input logic req, input logic irl, input logic pcl, input logic we,
                                       input logic jal, input logic jalr, input logic [1:0] opm,
                                       input logic [1:0] ula, input logic rd, input logic wr);
        return {req, irl, pcl, we, jal, jalr, opm, ula, rd, wr};
    endfunction

    function automatic cyc_t mk(input logic [6:0] op, input logic iv, input logic dr,
                                input logic [11:0] exp, input string ph);
        cyc_t c;
        c.op = op; c.iv = iv; c.dr = dr; c.exp = exp; c.ph = ph;
        return c;
    endfunction

    function automatic logic [11:0] observe();
        return {imem_req, IR_load, PC_load, rf_we, JAL, JALR, OP_MEM_I, ULAop, dmem_rd, dmem_wr};
    endfunction

    // Called at a negedge with the DUT in FETCH; returns at a negedge with the DUT back in FETCH (or HALT).
    task automatic run_instr(input logic [6:0] op, input int fd, input int md, input string tag);
        cyc_t q[$];
        int   c;
        bit   retires;
        bit   trap;
        logic [11:0] e;
        logic [11:0] obs;
        c = classify(op);
`ifdef UC_ILLEGAL_TRAP_EN
        trap = (c == 9);
`else
        trap = 1'b0;
`endif
        retires = !trap;

        checks++;
        if (instret !== W'(model_count)) begin
            errors++;
            $display("FAIL %s instret: got %0d expected %0d", tag, instret, W'(model_count));
        end

        for (int i = 0; i <= fd; i++)
            q.push_back(mk(7'($urandom), (i == fd), 1'($urandom),
                           pk(1'b1, (i == fd), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0), "fetch"));
        q.push_back(mk(op, 1'($urandom), 1'($urandom), 12'd0, "decode"));

        case (c)
            4:       e = pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
            5:       e = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0);
            6:       e = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
            9:       e = pk(1'b0, 1'b0, !trap, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
            default: e = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ula_of(c), 1'b0, 1'b0);
        endcase
        q.push_back(mk(7'($urandom), 1'($urandom), 1'($urandom), e, "exec"));

        if (c == 0 || c == 1)
            for (int j = 0; j <= md; j++)
                q.push_back(mk(7'($urandom), 1'($urandom), (j == md),
                               pk(1'b0, 1'b0, (c == 1) && (j == md), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                                  (c == 0), (c == 1)), "mem"));

        if (c == 0 || c == 2 || c == 3 || c == 7 || c == 8)
            q.push_back(mk(7'($urandom), 1'($urandom), 1'($urandom),
                           pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                              (c == 0) ? 2'b01 : (c == 7 || c == 8) ? 2'b10 : 2'b00,
                              ula_of(c), 1'b0, 1'b0), "wb"));

        foreach (q[k]) begin
            opcode     = q[k].op;
            imem_valid = q[k].iv;
            dmem_ready = q[k].dr;
            #1;
            obs = observe();
            checks++;
            if (obs !== q[k].exp) begin
                errors++;
                $display("FAIL %s op=%b %s c%0d: got %b expected %b", tag, op, q[k].ph, k, obs, q[k].exp);
            end
            @(negedge clk);
        end
        if (retires) model_count++;
    endtask

    task automatic test_reset();
        reset = 1'b0; imem_valid = 1'b1; dmem_ready = 1'b1; opcode = 7'b0110011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (observe() !== 12'd0 || instret !== '0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got %b instret %0d illegal %b expected all zero",
                         observe(), instret, illegal);
            end
        end
        @(negedge clk);
        reset = 1'b1; imem_valid = 1'b0;
        #1;
        checks++;
        if (observe() !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_release: got %b expected imem_req only", observe());
        end
        @(negedge clk);
        model_count = 0;
    endtask

    task automatic test_directed();
        run_instr(7'b0110011, 0, 0, "add");
        run_instr(7'b0000011, 0, 3, "lw_wait3");
        run_instr(7'b1101111, 0, 0, "jal");
        run_instr(7'b1100011, 0, 0, "beq");
        run_instr(7'b0100011, 2, 1, "sw");
        run_instr(7'b0110111, 1, 0, "lui");
    endtask

    task automatic test_random();
        logic [6:0] legal [9];
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111};
        for (int n = 0; n < 60; n++)
            run_instr(legal[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    endtask

    task automatic test_illegal();
`ifdef UC_ILLEGAL_TRAP_EN
        run_instr(7'b1111111, 0, 0, "illegal_trap");
        for (int i = 0; i < 5; i++) begin
            opcode = 7'($urandom); imem_valid = 1'b1; dmem_ready = 1'b1;
            #1;
            checks++;
            if (observe() !== 12'd0 || illegal !== 1'b1 || instret !== W'(model_count)) begin
                errors++;
                $display("FAIL halt: got %b illegal %b instret %0d expected zero strobes, illegal 1, instret %0d",
                         observe(), illegal, instret, W'(model_count));
            end
            @(negedge clk);
        end
        reset = 1'b0; imem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_count = 0;
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: got %b expected 0", illegal);
        end
        @(negedge clk);
`else
        run_instr(7'b1111111, 0, 0, "illegal_nop");
        run_instr(7'b0000000, 1, 0, "illegal_zero");
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_tied: got %b expected 0", illegal);
        end
`endif
        run_instr(7'b0010011, 0, 0, "after_illegal");
    endtask

    task automatic test_mem_reset();
        opcode = 7'($urandom); imem_valid = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        opcode = 7'b0100011; imem_valid = 1'b0;
        @(negedge clk);
        opcode = 7'($urandom);
        @(negedge clk);
        #1;
        checks++;
        if (dmem_wr !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL sw_mem: got dmem_wr %b rf_we %b expected 1 0", dmem_wr, rf_we);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (dmem_wr !== 1'b0 || observe() !== 12'd0 || instret !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b instret %0d expected zero strobes and instret 0",
                     observe(), instret);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL restart_fetch: got imem_req %b expected 1", imem_req);
        end
        @(negedge clk);
        model_count = 0;
        run_instr(7'b1100111, 0, 0, "jalr_after_reset");
        run_instr(7'b0000011, 1, 0, "lw_after_reset");
    endtask

    initial begin
        opcode = '0; imem_valid = 1'b0; dmem_ready = 1'b0; reset = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_illegal();
        test_mem_reset();
        run_instr(7'b0010111, 0, 0, "final_auipc");
        checks++;
        if (instret !== W'(model_count)) begin
            errors++;
            $display("FAIL final_instret: got %0d expected %0d", instret, W'(model_count));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
